// File: rtl/my_mul.sv
// ---------------------------------------------------------------------------
// my_mul -- sequential shift-add multiplier.
//
// Multiplies an unsigned MULTIPLICAND_WIDTH operand by an unsigned
// MULTIPLIER_WIDTH operand. One multiplier bit is consumed per clock, so a
// result takes exactly MULTIPLIER_WIDTH CALC cycles. There is no early exit,
// which keeps the latency fixed. Typical use is re-multiplying
// quotient * divisor to check a divider result.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     operands present
//   in_ready     block can accept operands (high only in IDLE)
//   multiplicand unsigned operand A
//   multiplier   unsigned operand B (0 is legal)
//   out_valid    product / overflow valid
//   out_ready    consumer accepts the result
//   product      full unsigned product (never truncated)
//   overflow     product does not fit in MULTIPLICAND_WIDTH bits
// ---------------------------------------------------------------------------
module my_mul #(
   parameter int MULTIPLICAND_WIDTH = 16,
   parameter int MULTIPLIER_WIDTH   = 5
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic [MULTIPLICAND_WIDTH-1:0]                multiplicand,
   input  logic [MULTIPLIER_WIDTH-1:0]                  multiplier,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] product,
   output logic                                         overflow
);

   localparam int PW = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
   localparam int CW = $clog2(MULTIPLIER_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(MULTIPLIER_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                      state;
   logic [PW-1:0]               mcand_q;   // multiplicand, shifted left each CALC cycle
   logic [PW-1:0]               acc_q;     // partial product; full width, cannot overflow
   logic [MULTIPLIER_WIDTH-1:0] mplier_q;  // multiplier, shifted right each CALC cycle
   logic [CW-1:0]               cnt_q;
   logic [PW-1:0]               acc_nxt;

   // Accumulator value after the current CALC step; also used on the final
   // step so the result can be registered straight into product.
   always_comb begin
      acc_nxt = acc_q;
      if (mplier_q[0])
         acc_nxt = acc_q + mcand_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         product   <= '0;
         overflow  <= 1'b0;
         mcand_q   <= '0;
         acc_q     <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand_q  <= {{MULTIPLIER_WIDTH{1'b0}}, multiplicand};
                  mplier_q <= multiplier;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc_q    <= acc_nxt;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  product   <= acc_nxt;
                  overflow  <= |acc_nxt[PW-1:MULTIPLICAND_WIDTH];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // product/overflow simply hold while the consumer stalls
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_my_mul.sv
module tb_my_mul;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] multiplicand;
   logic [4:0]  multiplier;
   logic        out_valid;
   logic        out_ready;
   logic [20:0] product;
   logic        overflow;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   my_mul #(.MULTIPLICAND_WIDTH(16), .MULTIPLIER_WIDTH(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .overflow(overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: plain integer multiplication.
   function automatic logic [63:0] ref_prod(input logic [15:0] a, input logic [4:0] b);
      return 64'(a) * 64'(b);
   endfunction

   function automatic logic ref_ovf(input logic [15:0] a, input logic [4:0] b);
      return ref_prod(a, b) > 64'd65535;
   endfunction

   // Offer one operand pair, hold the result for 'hold' cycles, then consume.
   task automatic run_op(input logic [15:0] a, input logic [4:0] b, input int hold);
      int n;
      @(negedge clk);
      multiplicand = a; multiplier = b; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      check("accept_ready", in_ready, 1);
      @(negedge clk);                       // accept edge has passed
      in_valid = 1'b0;
      check("busy", in_ready, 0);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      check("latency", n, 5);
      check("product", product, ref_prod(a, b));
      check("overflow", overflow, ref_ovf(a, b));
      for (int i = 0; i < hold; i++) begin
         multiplicand = 16'($urandom); multiplier = 5'($urandom);
         in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_prod", product, ref_prod(a, b));
         check("hold_ovf", overflow, ref_ovf(a, b));
         check("hold_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("consumed", out_valid, 0);
      check("idle_ready", in_ready, 1);
   endtask

   initial begin
      logic [63:0] exp_q[$];
      logic        exp_o[$];
      int n, sent, done, cyc;
      bit need;
      logic [15:0] ra;
      logic [4:0]  rb;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      multiplicand = '0; multiplier = '0;
      @(negedge clk);
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_prod", product, 0);
      check("rst_ovf", overflow, 0);
      @(negedge clk);
      rst = 1'b0;

      // directed cases
      run_op(16'd1234, 5'd7, 0);
      check("p_1234x7", product, 8638);
      run_op(16'd65535, 5'd31, 0);
      check("p_max", product, 21'h1EFFE1);
      check("ovf_max", overflow, 1);
      run_op(16'd0, 5'd31, 0);
      run_op(16'd40000, 5'd0, 0);
      check("p_zero_b", product, 0);
      run_op(16'd300, 5'd31, 10);
      check("p_300x31", product, 9300);

      // reset during the third CALC cycle
      @(negedge clk);
      multiplicand = 16'd65535; multiplier = 5'd31; in_valid = 1'b1;
      @(negedge clk);                       // accepted (in_ready was 1)
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_ready", in_ready, 1);
      check("abort_prod", product, 0);
      check("abort_ovf", overflow, 0);
      @(negedge clk);
      rst = 1'b0;
      run_op(16'd2, 5'd3, 0);
      check("p_2x3", product, 6);

      // back-to-back: second pair accepted on the edge after DONE->IDLE
      @(negedge clk);
      multiplicand = 16'd5; multiplier = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);                       // accept edge E0 passed
      multiplicand = 16'd9; multiplier = 5'd9;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      check("b2b_gap", n, 6);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      check("b2b_lat", n, 5);
      check("b2b_prod", product, 81);
      @(negedge clk);
      out_ready = 1'b0;

      // randomized stream against the model, random backpressure
      sent = 0; done = 0; cyc = 0; need = 1'b1;
      while (done < 1000 && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         out_ready = ($urandom_range(0, 3) != 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("rnd_spurious", out_valid, 0);
            else begin
               check("rnd_prod", product, exp_q.pop_front());
               check("rnd_ovf", overflow, exp_o.pop_front());
               done++;
            end
         end
         if (need) begin
            if (sent < 1000) begin
               ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
               rb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
               multiplicand = ra; multiplier = rb; in_valid = 1'b1;
               need = 1'b0;
            end else in_valid = 1'b0;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_prod(ra, rb));
            exp_o.push_back(ref_ovf(ra, rb));
            sent++;
            need = 1'b1;
         end
      end
      check("rnd_done", done, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
